aidc_lite_comp_sel: RTL and testbench

Output selector and drain controller for the AIDC-Lite compression path. It tracks the SR and ZRLE compressors while one 128-byte block is compressed. Once both report completion, it picks the shortest non-failed result and streams it from that compressor's 16×64-bit buffer to the engine as 32-bit words. It replaces the engine's tied-off `comp_ready`/`comp_rden`/`comp_rdata` hookup and the buffers' constant read addresses.

---
 rtl/aidc_lite_comp_pkg.sv | 23 ++
 rtl/aidc_lite_comp_len_trk.sv | 65 ++++++
 rtl/aidc_lite_comp_sel.sv | 235 +++++++++++++++++++++++
 tb/tb_aidc_lite_comp_sel.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aidc_lite_comp_pkg.sv
// Shared definitions for the AIDC-Lite compressor output selector.
package aidc_lite_comp_pkg;

  // Compressor buffer geometry: 16 entries of 64 bits.
  localparam int BUF_ADDR_W = 4;
  localparam int BUF_DEPTH  = 16;
  localparam int BUF_DATA_W = 64;

  // Source select encoding presented on sel_o.
  localparam logic [1:0] SEL_SR   = 2'd0;
  localparam logic [1:0] SEL_ZRLE = 2'd1;
  localparam logic [1:0] SEL_NONE = 2'd3;

  // Selector control states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DECIDE,
    ST_FETCH,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/aidc_lite_comp_len_trk.sv
// Per-compressor tracker: highest-written-entry counter plus done/fail latch.
module aidc_lite_comp_len_trk
  import aidc_lite_comp_pkg::*;
#(
  parameter int ADDR_W = BUF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              done_i,
  input  logic              fail_i,
  output logic [ADDR_W:0]   cnt_o,
  output logic              done_o,
  output logic              fail_o
);

  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [ADDR_W:0] addr_p1;
  logic            done_q, done_d;
  logic            fail_q, fail_d;

  assign addr_p1 = {1'b0, addr_i} + (ADDR_W+1)'(1);

  // Counter grows to cover the highest written address; a done with nothing
  // written (same-cycle write included) counts as a failure.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    fail_d = fail_q;
    if (clr_i) begin
      cnt_d  = '0;
      done_d = 1'b0;
      fail_d = 1'b0;
    end else if (en_i) begin
      if (valid_i && (addr_p1 > cnt_q)) begin
        cnt_d = addr_p1;
      end
      if (done_i) begin
        done_d = 1'b1;
        fail_d = fail_i || (cnt_d == '0);
      end
    end
  end

  // Tracker state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      fail_q <= fail_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = done_q;
  assign fail_o = fail_q;

endmodule

// File: rtl/aidc_lite_comp_sel.sv
// AIDC-Lite output selector: picks the shortest good compressor result and
// streams its 64-bit buffer entries to the engine as 32-bit words.
module aidc_lite_comp_sel
  import aidc_lite_comp_pkg::*;
#(
  parameter int ADDR_W = BUF_ADDR_W,
  parameter int DATA_W = BUF_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sop_i,
  input  logic                sr_valid_i,
  input  logic [ADDR_W-1:0]   sr_addr_i,
  input  logic                sr_done_i,
  input  logic                sr_fail_i,
  input  logic                zrle_valid_i,
  input  logic [ADDR_W-1:0]   zrle_addr_i,
  input  logic                zrle_done_i,
  input  logic                zrle_fail_i,
  output logic [ADDR_W-1:0]   sr_raddr_o,
  output logic [ADDR_W-1:0]   zrle_raddr_o,
  input  logic [DATA_W-1:0]   sr_rdata_i,
  input  logic [DATA_W-1:0]   zrle_rdata_i,
  output logic                ready_o,
  input  logic                rden_i,
  output logic [DATA_W/2-1:0] rdata_o,
  output logic [1:0]          sel_o,
  output logic [ADDR_W+1:0]   len_o,
  output logic                result_valid_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int HALF_W = DATA_W / 2;
  localparam int CNT_W  = ADDR_W + 1;

  state_e              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [ADDR_W+1:0]   len_q, len_d;
  logic                rv_q, rv_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                half_q, half_d;
  logic                last_q, last_d;
  logic                ready_q, ready_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [HALF_W-1:0]   rdata_q, rdata_d;

  logic                trk_clr, trk_en;
  logic [CNT_W-1:0]    sr_cnt, zrle_cnt, sel_cnt, cand_cnt;
  logic                sr_done_f, sr_fail_f, zrle_done_f, zrle_fail_f;
  logic [1:0]          cand_sel;
  logic [DATA_W-1:0]   sel_rdata;
  logic                is_last;
  logic                collect;

  assign collect = (state_q == ST_COLLECT);
  assign trk_clr = (state_q == ST_IDLE) && sop_i;
  assign trk_en  = collect;

  aidc_lite_comp_len_trk #(.ADDR_W(ADDR_W)) u_sr_trk (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (trk_clr),
    .en_i    (trk_en),
    .valid_i (sr_valid_i),
    .addr_i  (sr_addr_i),
    .done_i  (sr_done_i),
    .fail_i  (sr_fail_i),
    .cnt_o   (sr_cnt),
    .done_o  (sr_done_f),
    .fail_o  (sr_fail_f)
  );

  aidc_lite_comp_len_trk #(.ADDR_W(ADDR_W)) u_zrle_trk (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (trk_clr),
    .en_i    (trk_en),
    .valid_i (zrle_valid_i),
    .addr_i  (zrle_addr_i),
    .done_i  (zrle_done_i),
    .fail_i  (zrle_fail_i),
    .cnt_o   (zrle_cnt),
    .done_o  (zrle_done_f),
    .fail_o  (zrle_fail_f)
  );

  // Shortest non-failed source wins; equal lengths favour SR.
  always_comb begin
    cand_sel = SEL_NONE;
    cand_cnt = '0;
    if (!sr_fail_f && (zrle_fail_f || (sr_cnt <= zrle_cnt))) begin
      cand_sel = SEL_SR;
      cand_cnt = sr_cnt;
    end else if (!zrle_fail_f) begin
      cand_sel = SEL_ZRLE;
      cand_cnt = zrle_cnt;
    end
  end

  assign sel_cnt   = (sel_q == SEL_ZRLE) ? zrle_cnt : sr_cnt;
  assign sel_rdata = (sel_q == SEL_ZRLE) ? zrle_rdata_i : sr_rdata_i;
  assign is_last   = ({1'b0, raddr_q} == (sel_cnt - CNT_W'(1)));

  // Next-state and output logic. The read address advances on the low-half
  // read so the buffer's one-cycle latency is hidden behind the high half.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    len_d   = len_q;
    rv_d    = rv_q;
    done_d  = 1'b0;
    half_d  = half_q;
    last_d  = last_q;
    ready_d = 1'b0;
    raddr_d = raddr_q;
    hold_d  = hold_q;
    rdata_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (sop_i) begin
          rv_d    = 1'b0;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if ((sr_done_f || sr_done_i) && (zrle_done_f || zrle_done_i)) begin
          state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        sel_d   = cand_sel;
        len_d   = {cand_cnt, 1'b0};
        rv_d    = 1'b1;
        raddr_d = '0;
        if (cand_sel == SEL_NONE) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        hold_d  = sel_rdata;
        half_d  = 1'b0;
        ready_d = 1'b1;
        rdata_d = sel_rdata[HALF_W-1:0];
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        ready_d = 1'b1;
        rdata_d = rdata_q;
        if (rden_i) begin
          if (!half_q) begin
            half_d  = 1'b1;
            rdata_d = hold_q[DATA_W-1:HALF_W];
            last_d  = is_last;
            if (!is_last) begin
              raddr_d = raddr_q + ADDR_W'(1);
            end
          end else begin
            ready_d = 1'b0;
            rdata_d = '0;
            if (last_q) begin
              done_d  = 1'b1;
              rv_d    = 1'b0;
              raddr_d = '0;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_FETCH;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky protocol error: misplaced start, reads without data, or
  // compressor activity outside the collection window.
  always_comb begin
    err_d = err_q;
    if ((sop_i && (state_q != ST_IDLE)) ||
        (rden_i && !ready_q) ||
        ((sr_done_i || zrle_done_i) && !collect) ||
        ((sr_valid_i || zrle_valid_i) && !collect)) begin
      err_d = 1'b1;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      len_q   <= '0;
      rv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      half_q  <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      raddr_q <= '0;
      hold_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      rv_q    <= rv_d;
      done_q  <= done_d;
      err_q   <= err_d;
      half_q  <= half_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      raddr_q <= raddr_d;
      hold_q  <= hold_d;
      rdata_q <= rdata_d;
    end
  end

  // The unselected buffer sees address 0.
  assign sr_raddr_o     = (sel_q == SEL_SR)   ? raddr_q : '0;
  assign zrle_raddr_o   = (sel_q == SEL_ZRLE) ? raddr_q : '0;
  assign ready_o        = ready_q;
  assign rdata_o        = rdata_q;
  assign sel_o          = sel_q;
  assign len_o          = len_q;
  assign result_valid_o = rv_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_aidc_lite_comp_sel.sv
// Bench for aidc_lite_comp_sel: buffer models, directed blocks, scoreboard.
module tb_aidc_lite_comp_sel;
  import aidc_lite_comp_pkg::*;

  localparam int AW = 4;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          sop;
  logic          sr_valid, sr_done, sr_fail;
  logic [AW-1:0] sr_addr;
  logic          zr_valid, zr_done, zr_fail;
  logic [AW-1:0] zr_addr;
  logic [AW-1:0] sr_raddr, zr_raddr;
  logic [DW-1:0] sr_rdata, zr_rdata;
  logic          ready_o, rden;
  logic [31:0]   rdata_o;
  logic [1:0]    sel_o;
  logic [5:0]    len_o;
  logic          rv_o, done_o, err_o;

  aidc_lite_comp_sel dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sop_i          (sop),
    .sr_valid_i     (sr_valid),
    .sr_addr_i      (sr_addr),
    .sr_done_i      (sr_done),
    .sr_fail_i      (sr_fail),
    .zrle_valid_i   (zr_valid),
    .zrle_addr_i    (zr_addr),
    .zrle_done_i    (zr_done),
    .zrle_fail_i    (zr_fail),
    .sr_raddr_o     (sr_raddr),
    .zrle_raddr_o   (zr_raddr),
    .sr_rdata_i     (sr_rdata),
    .zrle_rdata_i   (zr_rdata),
    .ready_o        (ready_o),
    .rden_i         (rden),
    .rdata_o        (rdata_o),
    .sel_o          (sel_o),
    .len_o          (len_o),
    .result_valid_o (rv_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  // Compressor buffers with one-cycle registered read.
  logic [DW-1:0] sr_mem [16];
  logic [DW-1:0] zr_mem [16];
  always @(posedge clk) begin
    sr_rdata <= sr_mem[sr_raddr];
    zr_rdata <= zr_mem[zr_raddr];
  end

  typedef struct packed {
    logic [1:0] sel;
    logic [5:0] len;
    logic       rv;
  } res_t;

  logic [31:0] exp_words[$];
  res_t        exp_res[$];
  int checks = 0;
  int errors = 0;
  int rises  = 0;
  int blk    = 0;

  function automatic logic [63:0] pattern(input bit src, input int b, input int a);
    logic [7:0] s, bb, aa;
    s  = src ? 8'hE0 : 8'h50;
    bb = 8'(b);
    aa = 8'(a);
    return {s, bb, aa, 8'h99, s, bb, aa, 8'h11};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, req);
    end
  endtask

  // Pops expectations whenever the DUT hands over a word or finishes a block.
  task automatic monitor();
    logic        prev = 1'b0;
    logic [31:0] w;
    res_t        r;
    int          nword = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (ready_o && !prev) rises++;
        prev = ready_o;
        if (ready_o && rden) begin
          checks++;
          if (exp_words.size() == 0) begin
            errors++;
            $display("FAIL word_unexpected got %h required none", rdata_o);
          end else begin
            w = exp_words.pop_front();
            if (rdata_o !== w) begin
              errors++;
              $display("FAIL word%0d got %h required %h", nword, rdata_o, w);
            end else begin
              $display("word%0d got %h required %h", nword, rdata_o, w);
            end
          end
          nword++;
        end
        if (done_o) begin
          checks++;
          if (exp_res.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected sel %0d len %0d", sel_o, len_o);
          end else begin
            r = exp_res.pop_front();
            if ({sel_o, len_o, rv_o} !== r) begin
              errors++;
              $display("FAIL result got sel %0d len %0d rv %0d required sel %0d len %0d rv %0d",
                       sel_o, len_o, rv_o, r.sel, r.len, r.rv);
            end else begin
              $display("done sel %0d len %0d rv %0d", sel_o, len_o, rv_o);
            end
          end
          chk("words_left_at_done", exp_words.size(), 0);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_block();
    blk++;
    sop = 1'b1;
    @(posedge clk); #1;
    sop = 1'b0;
  endtask

  task automatic write_buf(input bit src, input int n);
    for (int a = 0; a < n; a++) begin
      if (src) begin
        zr_mem[a] = pattern(1'b1, blk, a);
        zr_valid  = 1'b1;
        zr_addr   = AW'(a);
      end else begin
        sr_mem[a] = pattern(1'b0, blk, a);
        sr_valid  = 1'b1;
        sr_addr   = AW'(a);
      end
      @(posedge clk); #1;
      sr_valid = 1'b0;
      zr_valid = 1'b0;
    end
  endtask

  task automatic pulse_done(input bit s, input bit sf, input bit z, input bit zf);
    sr_done = s; sr_fail = sf; zr_done = z; zr_fail = zf;
    @(posedge clk); #1;
    sr_done = 1'b0; sr_fail = 1'b0; zr_done = 1'b0; zr_fail = 1'b0;
  endtask

  task automatic push_words(input bit src, input int n);
    logic [63:0] p;
    for (int e = 0; e < n; e++) begin
      p = pattern(src, blk, e);
      exp_words.push_back(p[31:0]);
      exp_words.push_back(p[63:32]);
    end
  endtask

  task automatic push_res(input logic [1:0] s, input int l, input logic v);
    res_t r;
    r.sel = s;
    r.len = 6'(l);
    r.rv  = v;
    exp_res.push_back(r);
  endtask

  // Consumes n words, only requesting when a word is offered.
  task automatic drain(input int n, input bit rnd, output int edges);
    int  got;
    bit  take;
    got   = 0;
    edges = 0;
    while (got < n && edges < 2000) begin
      rden = ready_o && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      take = ready_o && rden;
      @(posedge clk); #1;
      if (take) got++;
      edges++;
    end
    rden = 1'b0;
    if (got < n) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout got %0d words required %0d", got, n);
    end
  endtask

  initial begin
    int lat, edges, r0;
    rst_n = 1'b1;
    sop = 0; rden = 0;
    sr_valid = 0; sr_addr = '0; sr_done = 0; sr_fail = 0;
    zr_valid = 0; zr_addr = '0; zr_done = 0; zr_fail = 0;
    for (int i = 0; i < 16; i++) begin
      sr_mem[i] = '0;
      zr_mem[i] = '0;
    end
    fork
      monitor();
    join_none

    // Reset state
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs",
           {ready_o, rdata_o, sel_o, len_o, rv_o, done_o, err_o, sr_raddr, zr_raddr}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // SR shorter, ZRLE completes last
    start_block();
    write_buf(1'b0, 5);
    pulse_done(1'b1, 1'b0, 1'b0, 1'b0);
    write_buf(1'b1, 10);
    push_words(1'b0, 5);
    push_res(SEL_SR, 10, 1'b0);
    pulse_done(1'b0, 1'b0, 1'b1, 1'b0);
    lat = 0;
    while (!ready_o && lat < 10) begin @(posedge clk); #1; lat++; end
    chk("done_to_ready_edges", lat, 2);
    chk("sel_during_drain", sel_o, SEL_SR);
    chk("len_during_drain", len_o, 10);
    chk("rv_during_drain", rv_o, 1);
    drain(10, 1'b0, edges);
    chk("drain_edges_10_words", edges, 14);
    idle(2);
    chk("pending_sr_shorter", exp_res.size(), 0);

    // Tie selects SR
    start_block();
    write_buf(1'b0, 7);
    write_buf(1'b1, 7);
    push_words(1'b0, 7);
    push_res(SEL_SR, 14, 1'b0);
    pulse_done(1'b1, 1'b0, 1'b1, 1'b0);
    drain(14, 1'b0, edges);
    idle(2);
    chk("pending_tie", exp_res.size(), 0);

    // Tie with SR failed selects ZRLE
    start_block();
    write_buf(1'b0, 7);
    write_buf(1'b1, 7);
    push_words(1'b1, 7);
    push_res(SEL_ZRLE, 14, 1'b0);
    pulse_done(1'b1, 1'b1, 1'b1, 1'b0);
    drain(14, 1'b0, edges);
    idle(2);
    chk("pending_tie_srfail", exp_res.size(), 0);

    // Both fail: immediate done, no stream
    start_block();
    write_buf(1'b0, 3);
    write_buf(1'b1, 3);
    push_res(SEL_NONE, 0, 1'b1);
    r0 = rises;
    pulse_done(1'b1, 1'b1, 1'b1, 1'b1);
    idle(6);
    chk("ready_rises_both_fail", rises - r0, 0);
    chk("pending_both_fail", exp_res.size(), 0);

    // Full length ZRLE with random backpressure
    start_block();
    write_buf(1'b0, 3);
    write_buf(1'b1, 16);
    push_words(1'b1, 16);
    push_res(SEL_ZRLE, 32, 1'b0);
    r0 = rises;
    pulse_done(1'b1, 1'b1, 1'b1, 1'b0);
    drain(32, 1'b1, edges);
    idle(2);
    chk("ready_rises_full", rises - r0, 16);
    chk("pending_full", exp_res.size(), 0);

    // sop during DRAIN flags an error without disturbing the stream
    chk("err_before_sop", err_o, 0);
    start_block();
    write_buf(1'b0, 4);
    write_buf(1'b1, 6);
    push_words(1'b0, 4);
    push_res(SEL_SR, 8, 1'b0);
    pulse_done(1'b1, 1'b0, 1'b1, 1'b0);
    drain(3, 1'b0, edges);
    sop = 1'b1;
    @(posedge clk); #1;
    sop = 1'b0;
    chk("err_after_sop", err_o, 1);
    drain(5, 1'b0, edges);
    idle(2);
    chk("pending_sop_err", exp_res.size(), 0);

    // Reset mid-drain aborts without done
    start_block();
    write_buf(1'b0, 8);
    write_buf(1'b1, 5);
    push_words(1'b1, 5);
    push_res(SEL_ZRLE, 10, 1'b0);
    pulse_done(1'b1, 1'b0, 1'b1, 1'b0);
    drain(5, 1'b0, edges);
    chk("ready_before_reset", ready_o, 1);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_drain",
           {ready_o, rdata_o, sel_o, len_o, rv_o, done_o, err_o, sr_raddr, zr_raddr}, 0);
    exp_words.delete();
    exp_res.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);

    // Fresh block after reset
    start_block();
    write_buf(1'b0, 6);
    write_buf(1'b1, 3);
    push_words(1'b1, 3);
    push_res(SEL_ZRLE, 6, 1'b0);
    pulse_done(1'b1, 1'b0, 1'b1, 1'b0);
    drain(6, 1'b1, edges);
    idle(2);
    chk("pending_after_reset", exp_res.size(), 0);
    chk("err_after_fresh_block", err_o, 0);
    chk("words_left_end", exp_words.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
